disp_scan: RTL
==============

# disp_scan

Multiplexed seven-segment scan controller sitting directly upstream of the segment decoder. Holds an N-digit BCD value with per-digit decimal points, time-multiplexes one digit at a time onto a shared 8-bit `num` code for the decoder, and drives the active-low digit enables. Adds anti-ghost gaps between digits, leading-zero blanking, and tear-free value updates latched at frame boundaries.

## Interface
- `N_DIG`, 4: number of digits; must be at least 2.
- `SCAN_DIV`, 50000: clock cycles per digit slot.
- `GAP_CYC`, 500: dark cycles at the start of each slot; must be at least 1 and less than `SCAN_DIV`.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: scan enable; low = display dark.
- `load` in 1: one-cycle strobe; capture `bcd`/`dp`.
- `bcd` in 4*N_DIG: digit i in bits [4i+3:4i]; digit 0 = rightmost.
- `dp` in N_DIG: decimal point per digit.
- `blank_lz` in 1: leading-zero blanking enable, sampled every cycle.
- `num` out 8: code to the decoder. 0–9 = digit, 10–19 = digit with point, 20 = blank, 21 = invalid marker.
- `dig_sel` out N_DIG: digit enables, active-low, at most one bit low.
- `frame_tick` out 1: one-cycle pulse at each frame wrap.

## Operation
- Registers:
  - display value `disp_bcd`/`disp_dp`.
  - pending value `pend_bcd`/`pend_dp` plus `pend_v`.
  - slot counter `c`, 0..SCAN_DIV-1.
  - digit index `idx`, 0..N_DIG-1.
- Reset values:
  - Internal: all value registers 0, `pend_v`=0, `c`=0, `idx`=0.
  - Outputs: `dig_sel` all ones, `num`=20, `frame_tick`=0.
- Slot phases (decided from `c`):
  - GAP: `c` < GAP_CYC. Gives `dig_sel` all ones and `num`=20.
  - SHOW: otherwise. Gives `dig_sel[idx]`=0 and the others 1, with `num`=code(idx).
- Counting:
  - `c` increments each enabled cycle.
  - At `c`=SCAN_DIV-1, `c` goes to 0 and `idx` goes to `idx`+1, wrapping N_DIG-1 to 0.
- code(i), with d = `disp_bcd` digit i:
  - d > 9: 21, regardless of dp.
  - Leading-zero blank: 20 when `blank_lz`=1, i>0, d=0, every higher digit is 0, and `disp_dp[i]`=0.
  - Otherwise: d + 10·`disp_dp[i]`.
- Load and update:
  - `load`=1 writes `bcd`/`dp` to pending and sets `pend_v`; a later `load` overwrites it.
  - Frame boundary = the cycle `c`=SCAN_DIV-1 and `idx`=N_DIG-1 with `en`=1.
  - At the boundary, if `pend_v`=1, pending is copied to display and `pend_v` clears.
  - `load` in the boundary cycle writes the input data straight to display and clears `pend_v`.
  - `load` while `en`=0 writes straight to display; `pend_v` stays 0.
- Enable low:
  - `c` and `idx` are forced to 0; outputs go dark (`dig_sel` all ones, `num`=20); `frame_tick`=0.
  - Scan restarts at digit 0, GAP phase, when `en` returns.
- `rst_n` low mid-scan or mid-load: next edge restores all reset values; pending data is discarded.

## Timing
- `num`, `dig_sel` and `frame_tick` are registered and reflect the phase/index of the previous cycle: one cycle of latency from the counter.
- `num` and `dig_sel` always change on the same edge, so no cycle has an enabled digit with a stale code.
- Each enabled digit is lit for SCAN_DIV−GAP_CYC cycles per slot. Frame period = N_DIG·SCAN_DIV cycles.
- `frame_tick` is high for exactly one cycle: the cycle after each frame boundary edge. It is not asserted after reset until the first full frame completes.
- Display changes become visible at the first SHOW phase of digit 0 after the boundary. No frame ever mixes old and new values.
- `load` takes effect in internal state on the next edge; it has no handshake and is always accepted.

## Test plan
All cases use N_DIG=4, SCAN_DIV=8, GAP_CYC=2.
- Reset then `en`=1, load bcd=0x1234, dp=0:
  - Digit-0 slot: `dig_sel`=1111 for 3 cycles (the reset value plus 2 gap cycles), then 1110 with `num`=4 for 6 cycles.
  - Digit 1 then shows 3, digit 2 shows 2, digit 3 shows 1.
  - `frame_tick` pulses once every 32 cycles.
- Load bcd=0x0050, dp=0b0010, `blank_lz`=1:
  - Digits 3 and 2 give `num`=20.
  - Digit 1 gives `num`=15.
  - Digit 0 gives `num`=0.
  - With `blank_lz`=0, digits 3 and 2 give `num`=0.
- Load 0x1111 mid-frame:
  - The current frame still shows the old value on all digits.
  - 0x1111 first appears on digit 0 right after `frame_tick`.
- Simultaneous events:
  - `load` of 0x9999 exactly on the boundary cycle: the next frame shows 9 on every digit, and `pend_v`=0 afterwards.
  - Two loads in one frame: only the second is displayed.
- Invalid data: bcd=0xA00F gives `num`=21 on digits 3 and 0, and `num`=0 on digits 2 and 1 (with `blank_lz`=0).
- Interruptions:
  - Drop `en` during digit 2: next cycle `dig_sel`=1111, `num`=20; on re-enable the scan restarts at digit 0, GAP phase.
  - `rst_n`=0 for one cycle mid-scan: all outputs return to reset values, and the display value clears to 0.

Source files
------------

// File: rtl/disp_scan_if.sv
// rtl/disp_scan_if.sv - scan controller value/control inputs and decoder-facing outputs
//
// Signals:
//   en         scan enable, low = display dark
//   load       one-cycle strobe capturing bcd/dp
//   bcd        packed BCD digits, digit 0 in bits [3:0] (rightmost)
//   dp         decimal point per digit
//   blank_lz   leading-zero blanking enable
//   num        code to the segment decoder (0-9, 10-19 with point, 20 blank, 21 invalid)
//   dig_sel    active-low digit enables
//   frame_tick one-cycle pulse after each frame wrap
interface disp_scan_if #(
    parameter int N_DIG = 4
);
    logic               en;
    logic               load;
    logic [4*N_DIG-1:0] bcd;
    logic [N_DIG-1:0]   dp;
    logic               blank_lz;
    logic [7:0]         num;
    logic [N_DIG-1:0]   dig_sel;
    logic               frame_tick;

    modport master (
        output en, load, bcd, dp, blank_lz,
        input  num, dig_sel, frame_tick
    );

    modport slave (
        input  en, load, bcd, dp, blank_lz,
        output num, dig_sel, frame_tick
    );
endinterface

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - multiplexed seven-segment scan controller with tear-free updates
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    disp_scan_if slave: en/load/bcd/dp/blank_lz in, num/dig_sel/frame_tick out
module disp_scan #(
    parameter int N_DIG    = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    disp_scan_if.slave  bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(N_DIG);

    logic [CW-1:0]      r_c;
    logic [IW-1:0]      r_idx;
    logic [4*N_DIG-1:0] r_disp_bcd;
    logic [N_DIG-1:0]   r_disp_dp;
    logic [4*N_DIG-1:0] r_pend_bcd;
    logic [N_DIG-1:0]   r_pend_dp;
    logic               r_pend_v;
    logic [7:0]         r_num;
    logic [N_DIG-1:0]   r_dig_sel;
    logic               r_frame_tick;

    logic               w_slot_end;
    logic               w_bnd;
    logic               w_gap;
    logic [7:0]         w_code;
    logic [N_DIG-1:0]   w_sel;
    logic               w_hz;
    logic [3:0]         w_d;

    assign w_slot_end = (r_c == CW'(SCAN_DIV - 1));
    assign w_bnd      = bus.en && w_slot_end && (r_idx == IW'(N_DIG - 1));
    assign w_gap      = (r_c < CW'(GAP_CYC));

    // Code for the current digit. Walk from the most significant digit down,
    // carrying "everything above me is zero" so leading zeros can be blanked.
    always_comb begin
        w_code = 8'd20;
        w_hz   = 1'b1;
        w_d    = 4'd0;
        w_sel  = '1;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            w_d = r_disp_bcd[4*i +: 4];
            if (IW'(i) == r_idx) begin
                w_sel[i] = 1'b0;
                if (w_d > 4'd9) begin
                    w_code = 8'd21;
                end else if (bus.blank_lz && (i > 0) && (w_d == 4'd0) && w_hz && !r_disp_dp[i]) begin
                    w_code = 8'd20;
                end else begin
                    w_code = {4'd0, w_d} + (r_disp_dp[i] ? 8'd10 : 8'd0);
                end
            end
            w_hz = w_hz && (w_d == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c          <= '0;
            r_idx        <= '0;
            r_disp_bcd   <= '0;
            r_disp_dp    <= '0;
            r_pend_bcd   <= '0;
            r_pend_dp    <= '0;
            r_pend_v     <= 1'b0;
            r_num        <= 8'd20;
            r_dig_sel    <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_bnd;
            if (!bus.en) begin
                r_c       <= '0;
                r_idx     <= '0;
                r_num     <= 8'd20;
                r_dig_sel <= '1;
                // Nothing is being scanned, so a load cannot tear a frame.
                if (bus.load) begin
                    r_disp_bcd <= bus.bcd;
                    r_disp_dp  <= bus.dp;
                    r_pend_v   <= 1'b0;
                end
            end else begin
                if (w_slot_end) begin
                    r_c   <= '0;
                    r_idx <= (r_idx == IW'(N_DIG - 1)) ? '0 : r_idx + IW'(1);
                end else begin
                    r_c <= r_c + CW'(1);
                end

                // Code and enable update on the same edge so a lit digit never
                // carries a stale code.
                if (w_gap) begin
                    r_num     <= 8'd20;
                    r_dig_sel <= '1;
                end else begin
                    r_num     <= w_code;
                    r_dig_sel <= w_sel;
                end

                if (w_bnd) begin
                    // A load on the boundary itself is the newest value and wins.
                    if (bus.load) begin
                        r_disp_bcd <= bus.bcd;
                        r_disp_dp  <= bus.dp;
                    end else if (r_pend_v) begin
                        r_disp_bcd <= r_pend_bcd;
                        r_disp_dp  <= r_pend_dp;
                    end
                    r_pend_v <= 1'b0;
                end else if (bus.load) begin
                    r_pend_bcd <= bus.bcd;
                    r_pend_dp  <= bus.dp;
                    r_pend_v   <= 1'b1;
                end
            end
        end
    end

    assign bus.num        = r_num;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.frame_tick = r_frame_tick;
endmodule
